hazard_controller: RTL
======================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding unit in the ID/EX boundary logic.
- Detects load-use hazards the forwarding network cannot resolve and stalls the front end.
- Flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Sequences a multi-cycle mult/div unit (MDU) over a req/ack/done handshake, holding the front end until the result returns, with a watchdog timeout.

Parameters:
- MDU_TIMEOUT, 64: maximum MDU_WAIT cycles before abort; legal range 2..1023.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- rs_id  in  5  ID-stage source register rs
- rt_id  in  5  ID-stage source register rt
- uses_rt_id  in  1  ID instruction reads rt as a source
- mdu_op_id  in  1  ID instruction is a mult/div
- rt_ex  in  5  EX-stage destination of a load
- memread_ex  in  1  EX instruction is a load
- branch_taken_ex  in  1  taken branch/jump resolved in EX
- mdu_ack  in  1  MDU accepted the request
- mdu_done  in  1  MDU result ready, single-cycle pulse
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID register cleared to a NOP
- idex_bubble  out  1  ID/EX register loaded with control zeros
- mdu_req  out  1  MDU request, level signal
- mdu_timeout_err  out  1  sticky flag, MDU watchdog expired
- ctrl_state  out  2  current FSM state encoding
- stall_count  out  CNT_W  cycles with pc_write=0
- flush_count  out  CNT_W  branch flush events

Behaviour:
- Reset (asynchronous): state=RUN, watchdog=0, mdu_timeout_err=0, counters=0.
  - Combinational outputs resolve to pc_write=1, ifid_write=1, all other outputs 0.
- load_use = memread_ex && rt_ex!=0 && (rt_ex==rs_id || (uses_rt_id && rt_ex==rt_id)).
- States (2-bit): RUN=00, MDU_REQ=01, MDU_WAIT=10, ABORT=11. Outputs are Mealy (state plus inputs).
- RUN, priority order:
  1. branch_taken_ex: ifid_flush=1, idex_bubble=1, PC written. No MDU issue. Stay in RUN.
  2. load_use: pc_write=0, ifid_write=0, idex_bubble=1. Stay in RUN. Single-cycle stall; the condition clears naturally as the load moves to MEM.
  3. mdu_op_id: pc_write=0, ifid_write=0, idex_bubble=1. Next state MDU_REQ.
  4. Otherwise no action.
- MDU_REQ:
  - mdu_req=1, front end stalled as above.
  - mdu_ack -> MDU_WAIT and watchdog cleared.
  - mdu_req must remain high until acked.
- MDU_WAIT:
  - Front end stalled; watchdog increments each cycle.
  - mdu_done -> RUN. That same cycle, pc_write=1, ifid_write=1, idex_bubble=0, so the mult/div advances to EX.
  - watchdog reaches MDU_TIMEOUT-1 without done -> ABORT.
- ABORT:
  - Exactly one cycle. Sets mdu_timeout_err (sticky until reset).
  - Front end released: pc_write=1, ifid_write=1, idex_bubble=1, so the op is dropped.
  - Next state RUN.
- mdu_done in any state other than MDU_WAIT is ignored.
- branch_taken_ex outside RUN cannot occur legally, because EX holds bubbles. It is ignored, and a DEBUG check must fire.
- load_use and branch_taken_ex in the same cycle: the flush wins; pc_write=1.
- stall_count increments every cycle pc_write=0; flush_count increments every cycle ifid_flush=1. Both saturate at all-ones, with no wrap.
- rst asserted mid-MDU transaction: returns to RUN immediately and mdu_req drops asynchronously.

Optional Feature:
- HAZARD_STATS_EN defined: stall_count and flush_count counters are instantiated as specified.
- Undefined: both ports are tied to 0 and the counter flops are not instantiated. FSM and control behaviour are identical either way.

Decomposition:
- Shared package pipeline_ctrl_pkg: hazard_state_t enum (RUN/MDU_REQ/MDU_WAIT/ABORT with the fixed encodings), REG_ZERO constant, default MDU_TIMEOUT.
- One natural sub-module, sat_counter (parameterized width, increment enable, saturate), instantiated twice under HAZARD_STATS_EN.

Test Plan:
- Load-use: memread_ex=1, rt_ex=5, rs_id=5 for 1 cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle; stall_count=1.
- Register zero: memread_ex=1, rt_ex=0, rs_id=0 -> no stall.
- Branch over load-use: branch_taken_ex=1 together with the load-use case above -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_count=1, stall_count unchanged.
- MDU handshake: mdu_op_id=1 -> MDU_REQ. mdu_ack arrives after 2 cycles, mdu_done 4 cycles later. Required: mdu_req high for 3 cycles, stall held 7 cycles, pc_write=1 on the done cycle, ctrl_state back to 00.
- MDU timeout: with MDU_TIMEOUT=8, ack then no done -> ABORT on the 9th cycle after ack, mdu_timeout_err=1 sticky, idex_bubble=1, then RUN.
- Reset mid-wait: rst asserted in MDU_WAIT -> mdu_req=0, ctrl_state=00, mdu_timeout_err=0 and counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encoding, the hard-wired zero register and the default MDU watchdog.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MDU_REQ  = 2'b01,
        MDU_WAIT = 2'b10,
        ABORT    = 2'b11
    } hazard_state_t;

    localparam logic [4:0]  REG_ZERO        = 5'd0;
    localparam int unsigned DEF_MDU_TIMEOUT = 64;
    localparam int unsigned WD_W            = 10;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter: counts enabled cycles and holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    // Count enabled cycles, freezing once the counter reaches all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Hazard / sequencing controller for the 5-stage pipeline.
// Stalls on unresolvable load-use hazards, flushes on taken branches in EX and
// sequences the multi-cycle MDU over req/ack/done with a watchdog.
// Build option: HAZARD_STATS_EN instantiates the stall/flush statistics counters;
// when undefined both counter ports read 0.
// Build option: DEBUG enables a check on illegal branch_taken_ex outside RUN.
module hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MDU_TIMEOUT = DEF_MDU_TIMEOUT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             uses_rt_id,
    input  logic             mdu_op_id,
    input  logic [4:0]       rt_ex,
    input  logic             memread_ex,
    input  logic             branch_taken_ex,
    input  logic             mdu_ack,
    input  logic             mdu_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             mdu_req,
    output logic             mdu_timeout_err,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    hazard_state_t   state, state_nx;
    logic [WD_W-1:0] watchdog, watchdog_nx;
    logic            load_use;

    assign load_use = memread_ex && (rt_ex != REG_ZERO) &&
                      ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));

    assign ctrl_state = state;

    // Mealy control outputs and next-state selection.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mdu_req     = 1'b0;
        state_nx    = state;
        watchdog_nx = watchdog;
        case (state)
            RUN: begin
                if (branch_taken_ex) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (mdu_op_id) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_nx    = MDU_REQ;
                end
            end
            MDU_REQ: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                mdu_req     = 1'b1;
                if (mdu_ack) begin
                    state_nx    = MDU_WAIT;
                    watchdog_nx = '0;
                end
            end
            MDU_WAIT: begin
                if (mdu_done) begin
                    // Release the front end this cycle so the op moves into EX.
                    state_nx = RUN;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (watchdog == WD_LAST) begin
                        state_nx = ABORT;
                    end else begin
                        watchdog_nx = watchdog + WD_ONE;
                    end
                end
            end
            ABORT: begin
                idex_bubble = 1'b1;
                state_nx    = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    // State, watchdog and sticky timeout flag; the flag rises as ABORT is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RUN;
            watchdog        <= '0;
            mdu_timeout_err <= 1'b0;
        end else begin
            state    <= state_nx;
            watchdog <= watchdog_nx;
            if (state_nx == ABORT) begin
                mdu_timeout_err <= 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (!pc_write),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (ifid_flush),
        .count (flush_count)
    );
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

`ifdef DEBUG
    // EX only holds bubbles outside RUN, so a taken branch there is a pipeline bug.
    always_ff @(posedge clk) begin
        if (!rst && (state != RUN)) begin
            assert (!branch_taken_ex)
                else $error("hazard_controller: branch_taken_ex outside RUN");
        end
    end
`endif

endmodule
